// File: rtl/instr_queue.sv
// instr_queue: fetch-to-decode FIFO of {addr, instr} pairs with first-word fall-through
// and a flush that discards wrong-path entries on a PC redirect.
module instr_queue #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 9,
    parameter int DEPTH   = 4
) (
    input  logic                       CLK,
    input  logic                       reset_n,
    input  logic                       flush_ctrl,
    input  logic                       in_valid,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [INSTR_W-1:0]         in_instr,
    output logic                       in_ready,
    output logic                       stall_ctrl,
    output logic                       out_valid,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [INSTR_W-1:0]         out_instr,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]      rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q  [DEPTH];
    logic [INSTR_W-1:0] instr_q [DEPTH];
    logic               push, pop;

    assign in_ready   = cnt_q != CW'(DEPTH);
    assign stall_ctrl = ~in_ready;
    assign out_valid  = cnt_q != '0;
    assign out_addr   = addr_q[rd_q];
    assign out_instr  = instr_q[rd_q];
    assign count      = cnt_q;
    assign push       = in_valid & in_ready;
    assign pop        = out_valid & out_ready;

    // Flush wins: a same-cycle push is dropped, a same-cycle pop is simply absorbed.
    always_comb begin
        rd_d  = flush_ctrl ? '0 : rd_q + PW'(pop);
        wr_d  = flush_ctrl ? '0 : wr_q + PW'(push);
        cnt_d = flush_ctrl ? '0 : cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= '0;
                instr_q[i] <= '0;
            end
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            if (push && !flush_ctrl) begin
                addr_q[wr_q]  <= in_addr;
                instr_q[wr_q] <= in_instr;
            end
        end
    end
endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: directed bench for instr_queue with a queue-based scoreboard
// of the entries expected at the decode side.
module tb_instr_queue;
    logic        CLK = 1'b0;
    logic        reset_n, flush_ctrl, in_valid, out_ready;
    logic [15:0] in_addr;
    logic [8:0]  in_instr;
    logic        in_ready, stall_ctrl, out_valid;
    logic [15:0] out_addr;
    logic [8:0]  out_instr;
    logic [2:0]  count;

    typedef struct packed {
        logic [15:0] a;
        logic [8:0]  i;
    } ent_t;

    ent_t sb[$];
    int   vecs = 0;
    int   errs = 0;

    instr_queue dut (
        .CLK(CLK), .reset_n(reset_n), .flush_ctrl(flush_ctrl),
        .in_valid(in_valid), .in_addr(in_addr), .in_instr(in_instr),
        .in_ready(in_ready), .stall_ctrl(stall_ctrl),
        .out_valid(out_valid), .out_addr(out_addr), .out_instr(out_instr),
        .out_ready(out_ready), .count(count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [8:0] ins_of(input logic [15:0] a);
        return a[8:0] ^ 9'h155;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check head, update model at posedge, check state.
    task automatic cycle(input logic fl, input logic iv, input logic [15:0] a, input logic ordy);
        logic push_m, pop_m;
        @(negedge CLK);
        flush_ctrl = fl;
        in_valid   = iv;
        in_addr    = a;
        in_instr   = ins_of(a);
        out_ready  = ordy;
        #1;
        chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("head_addr", 32'(out_addr), 32'(sb[0].a));
            chk("head_instr", 32'(out_instr), 32'(sb[0].i));
        end
        push_m = iv && sb.size() < 4;
        pop_m  = ordy && sb.size() != 0;
        @(posedge CLK);
        if (pop_m) void'(sb.pop_front());
        if (fl) sb.delete();
        else if (push_m) sb.push_back({a, ins_of(a)});
        #1;
        chk("count", 32'(count), 32'(sb.size()));
        chk("in_ready", 32'(in_ready), 32'(sb.size() != 4));
        chk("stall", 32'(stall_ctrl), 32'(sb.size() == 4));
    endtask

    task automatic async_reset(input string tag);
        @(negedge CLK);
        #2;
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        flush_ctrl = 1'b0;
        #1;
        sb.delete();
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_stall"}, 32'(stall_ctrl), 32'd0);
        chk({tag, "_addr"}, 32'(out_addr), 32'd0);
        chk({tag, "_instr"}, 32'(out_instr), 32'd0);
        @(negedge CLK);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1; flush_ctrl = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_addr = '0; in_instr = '0;
        async_reset("por");
        // Mid-run reset with three entries queued
        for (int k = 1; k <= 3; k++) cycle(1'b0, 1'b1, 16'(k), 1'b0);
        chk("pre_rst_count", 32'(count), 32'd3);
        async_reset("rst3");
        // Fill to full, fifth push ignored
        for (int k = 0; k <= 4; k++) cycle(1'b0, 1'b1, 16'(k), 1'b0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_head", 32'(out_addr), 32'd0);
        // Drain in order
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 16'hdead, 1'b1);
        cycle(1'b0, 1'b0, 16'hdead, 1'b1);
        // Streaming through wrapping pointers
        for (int k = 10; k <= 20; k++) cycle(1'b0, 1'b1, 16'(k), 1'b1);
        cycle(1'b0, 1'b0, 16'hdead, 1'b1);
        // Flush with a same-cycle push
        for (int k = 5; k <= 7; k++) cycle(1'b0, 1'b1, 16'(k), 1'b0);
        cycle(1'b1, 1'b1, 16'd8, 1'b0);
        chk("flush_count", 32'(count), 32'd0);
        cycle(1'b0, 1'b1, 16'h42, 1'b0);
        cycle(1'b0, 1'b0, 16'hdead, 1'b1);
        // Full boundary: pop at full does not free room for a same-edge push
        for (int k = 30; k <= 33; k++) cycle(1'b0, 1'b1, 16'(k), 1'b0);
        cycle(1'b0, 1'b1, 16'd99, 1'b1);
        chk("bound_count", 32'(count), 32'd3);
        cycle(1'b0, 1'b1, 16'd100, 1'b0);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 16'hdead, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
